// File: rtl/two_stage_pipeline_unloader_pkg.sv
// ---------------------------------------------------------------------------
// two_stage_pkg
// Shared definitions for the two-stage pipeline loader/unloader pair.
//   state_t : 2-bit controller state. S_wait belongs to the loader only and
//             is treated as an illegal code by the unloader.
//   W_DEF   : default half-word width.
// ---------------------------------------------------------------------------
package two_stage_pkg;

    typedef enum logic [1:0] {
        S_idle = 2'b00,
        S_1    = 2'b01,
        S_0    = 2'b10,
        S_wait = 2'b11
    } state_t;

    localparam int unsigned W_DEF = 4;

endpackage

// File: rtl/two_stage_pipeline_unloader_ctrl.sv
// ---------------------------------------------------------------------------
// two_stage_unloader_ctrl
// Handshake controller for the unloader: owns the FSM and the R0-full flag.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   clr           : synchronous flush (highest priority)
//   in_valid      : producer offers a packed word
//   out_ready     : consumer accepts the current half
//   ld_r0         : load R0 from the input this edge
//   xfer          : move R0 into the P1/P0 output stage this edge
//   cnt_inc       : a word's second half is accepted this edge
//   in_ready      : registered, equals ~r0_full
//   out_valid     : registered, a half is being presented
//   out_last      : registered, the presented half is P0
//   state         : current FSM state
// ---------------------------------------------------------------------------
module two_stage_unloader_ctrl
    import two_stage_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   clr,
    input  logic   in_valid,
    input  logic   out_ready,
    output logic   ld_r0,
    output logic   xfer,
    output logic   cnt_inc,
    output logic   in_ready,
    output logic   out_valid,
    output logic   out_last,
    output state_t state
);

    state_t r_state;
    logic   r_r0_full;
    logic   r_in_ready;
    logic   r_out_valid;
    logic   r_out_last;
    logic   w_emit_last;

    // Accept needs R0 empty and transfer needs R0 full, so the two never
    // coincide; clr suppresses all three strobes.
    always_comb begin
        w_emit_last = (r_state == S_0) && out_ready;
        ld_r0       = in_valid && r_in_ready && !clr;
        xfer        = r_r0_full && ((r_state == S_idle) || w_emit_last) && !clr;
        cnt_inc     = w_emit_last && !clr;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_idle;
            r_r0_full   <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (clr) begin
            r_state     <= S_idle;
            r_r0_full   <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            if (ld_r0) begin
                r_r0_full  <= 1'b1;
                r_in_ready <= 1'b0;
            end else if (xfer) begin
                r_r0_full  <= 1'b0;
                r_in_ready <= 1'b1;
            end

            // Outputs are registered from the next state so they line up
            // with the state register.
            case (r_state)
                S_idle: begin
                    if (xfer) begin
                        r_state     <= S_1;
                        r_out_valid <= 1'b1;
                        r_out_last  <= 1'b0;
                    end
                end
                S_1: begin
                    if (out_ready) begin
                        r_state     <= S_0;
                        r_out_valid <= 1'b1;
                        r_out_last  <= 1'b1;
                    end
                end
                S_0: begin
                    if (out_ready) begin
                        if (r_r0_full) begin
                            r_state     <= S_1;
                            r_out_valid <= 1'b1;
                            r_out_last  <= 1'b0;
                        end else begin
                            r_state     <= S_idle;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= S_idle;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                end
            endcase
        end
    end

    assign state     = r_state;
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;

endmodule

// File: rtl/two_stage_pipeline_unloader.sv
// ---------------------------------------------------------------------------
// two_stage_pipeline_unloader
// Takes one packed {P1,P0} word into R0 and emits it as two W-bit halves,
// P1 then P0, sustaining one half per cycle when both sides stream.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   clr        : synchronous flush; word_cnt is preserved
//   in_valid / in_ready / in_data    : packed-word input handshake
//   out_valid / out_ready / out_data / out_last : half-word output handshake
//   word_cnt   : words fully emitted, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module two_stage_pipeline_unloader
    import two_stage_pkg::*;
#(
    parameter int unsigned W     = W_DEF,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [2*W-1:0]   in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic [CNT_W-1:0] word_cnt
);

    logic [2*W-1:0]   r_r0;
    logic [W-1:0]     r_p1;
    logic [W-1:0]     r_p0;
    logic [CNT_W-1:0] r_word_cnt;

    logic   w_ld_r0;
    logic   w_xfer;
    logic   w_cnt_inc;
    state_t w_state;

    two_stage_unloader_ctrl u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .ld_r0     (w_ld_r0),
        .xfer      (w_xfer),
        .cnt_inc   (w_cnt_inc),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_last  (out_last),
        .state     (w_state)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_r0       <= '0;
            r_p1       <= '0;
            r_p0       <= '0;
            r_word_cnt <= '0;
        end else if (clr) begin
            r_r0 <= '0;
            r_p1 <= '0;
            r_p0 <= '0;
        end else begin
            if (w_ld_r0) begin
                r_r0 <= in_data;
            end
            if (w_xfer) begin
                {r_p1, r_p0} <= r_r0;
            end
            if (w_cnt_inc) begin
                r_word_cnt <= r_word_cnt + CNT_W'(1);
            end
        end
    end

    // P0 is shown only in S_0; otherwise P1 (zero after reset/flush).
    assign out_data = (w_state == S_0) ? r_p0 : r_p1;
    assign word_cnt = r_word_cnt;

endmodule

// File: tb/tb_two_stage_pipeline_unloader.sv
module tb_two_stage_pipeline_unloader;

    localparam int unsigned W = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       out_ready = 1'b0;

    logic       in_ready, out_valid, out_last;
    logic [3:0] out_data;
    logic [7:0] word_cnt;

    logic       in_ready_b, out_valid_b, out_last_b;
    logic [3:0] out_data_b;
    logic [1:0] word_cnt_b;

    always #5 clk = ~clk;

    two_stage_pipeline_unloader #(.W(W), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .word_cnt(word_cnt)
    );

    two_stage_pipeline_unloader #(.W(W), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_b),
        .out_valid(out_valid_b), .out_data(out_data_b), .out_last(out_last_b),
        .out_ready(out_ready), .word_cnt(word_cnt_b)
    );

    // Reference model: one held word waiting in the input slot, plus the
    // word being emitted with the number of its halves still to go.
    bit          m_hold;
    logic [7:0]  m_hold_w;
    logic [7:0]  m_pipe_w;
    int          m_left;
    int unsigned m_cnt;

    int total = 0;
    int bad   = 0;

    logic [7:0] src[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hold   = 0;
        m_hold_w = '0;
        m_pipe_w = '0;
        m_left   = 0;
        m_cnt    = 0;
    endtask

    task automatic model_edge();
        bit acc;
        int nl;
        if (clr) begin
            m_hold = 0;
            m_left = 0;
        end else begin
            acc = in_valid && !m_hold;
            nl  = m_left;
            if (m_left > 0 && out_ready) begin
                nl = m_left - 1;
                if (m_left == 1) m_cnt++;
            end
            if (m_hold && nl == 0) begin
                m_pipe_w = m_hold_w;
                nl       = 2;
                m_hold   = 0;
            end
            m_left = nl;
            if (acc) begin
                m_hold   = 1;
                m_hold_w = in_data;
            end
        end
    endtask

    task automatic check_all();
        logic [3:0] exp_half;
        exp_half = (m_left == 2) ? m_pipe_w[7:4] : m_pipe_w[3:0];
        chk("in_ready",  in_ready,  !m_hold);
        chk("out_valid", out_valid, m_left > 0);
        chk("out_last",  out_last,  m_left == 1);
        if (m_left > 0) chk("out_data", out_data, exp_half);
        chk("word_cnt",  word_cnt,  m_cnt % 256);
        chk("b_in_ready",  in_ready_b,  !m_hold);
        chk("b_out_valid", out_valid_b, m_left > 0);
        chk("b_out_last",  out_last_b,  m_left == 1);
        if (m_left > 0) chk("b_out_data", out_data_b, exp_half);
        chk("b_word_cnt",  word_cnt_b,  m_cnt % 4);
    endtask

    task automatic cycle(input logic iv, input logic [7:0] d, input logic ordy, input logic c);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        clr       = c;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    // Offers words from src in order; ordy_mode 0=low, 1=high, 2=random.
    task automatic run(input int n, input int ordy_mode);
        logic       ord;
        logic       iv;
        logic [7:0] d;
        bit         will_acc;
        for (int i = 0; i < n; i++) begin
            ord      = (ordy_mode == 2) ? 1'($urandom_range(0, 1)) : (ordy_mode == 1);
            iv       = (src.size() > 0);
            d        = iv ? src[0] : 8'h00;
            will_acc = iv && !m_hold;
            cycle(iv, d, ord, 1'b0);
            if (will_acc) void'(src.pop_front());
        end
    endtask

    task automatic async_reset();
        #2 rst = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rst_data", out_data, 4'h0);
        @(negedge clk);
        rst = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clr       = 1'b0;
        #1;
        check_all();
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check_all();
        chk("init_data", out_data, 4'h0);
        @(negedge clk);

        // single word A5
        cycle(1'b1, 8'hA5, 1'b1, 1'b0);
        repeat (5) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // streaming 12,34,56
        src = '{8'h12, 8'h34, 8'h56};
        run(10, 1);

        // backpressure C3,7E then release
        src = '{8'hC3, 8'h7E};
        run(6, 0);
        run(8, 1);

        // flush in S_0 with R0 full, simultaneous offer ignored
        src = '{8'hC3, 8'h7E};
        run(4, 0);
        src.delete();
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b1, 8'h99, 1'b0, 1'b1);
        repeat (4) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // counter wrap: five words
        src = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        run(14, 1);

        // random streams with random backpressure
        for (int i = 0; i < 20; i++) src.push_back(8'($urandom));
        run(80, 2);
        src.delete();

        // reset in the middle of a word
        src = '{8'hDE, 8'hAD};
        run(3, 1);
        src.delete();
        async_reset();
        cycle(1'b1, 8'hB7, 1'b1, 1'b0);
        repeat (4) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // fully random, occasional flush
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 24) == 0));
        end
        repeat (4) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
